// File: rtl/pipe_divmod.sv
// Pipelined restoring divider: NW-bit dividend by DW-bit divisor, unsigned or truncating signed.
// An operation accepted at edge k raises out_valid after edge k+LAT; back-pressure freezes every stage.
module pipe_divmod #(
  parameter int unsigned NW     = 8,
  parameter int unsigned DW     = 4,
  parameter bit          SIGNED = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] A,
  input  logic [DW-1:0] B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] C,
  output logic [DW-1:0] R,
  output logic          dz,
  output logic          ovf
);

  localparam int unsigned LAT = NW + 2;
  localparam logic [NW-1:0] MinA = {1'b1, {(NW-1){1'b0}}};

  logic stall;

  // Stage 0 operand conditioning
  logic          sgn_a;
  logic          sgn_b;
  logic [NW-1:0] mag_a;
  logic [DW-1:0] mag_b;

  // Stage registers: index 0 is the input stage, 1..NW the iterations, NW+1 the sign fix-up
  logic          vld_q   [LAT];
  logic          dz_s_q  [LAT];
  logic          ovf_s_q [LAT];
  logic [DW-1:0] rem_q   [NW+1];
  logic [NW-1:0] quo_q   [NW+1];
  logic [DW-1:0] dvs_q   [NW];
  logic          negq_q  [NW+1];
  logic          negr_q  [NW+1];
  logic [DW-1:0] rem_d   [1:NW];
  logic [NW-1:0] quo_d   [1:NW];

  logic [NW-1:0] fix_c;
  logic [DW-1:0] fix_r;
  logic [NW-1:0] fc_q;
  logic [DW-1:0] fr_q;

  logic [NW-1:0] c_d, c_q;
  logic [DW-1:0] r_d, r_q;
  logic          dz_d, dz_q;
  logic          ovf_d, ovf_q;
  logic          out_vld_q;

  assign out_valid = out_vld_q;
  assign C         = c_q;
  assign R         = r_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;

  assign stall    = out_vld_q & ~out_ready;
  assign in_ready = ~stall;

  assign sgn_a = SIGNED && A[NW-1];
  assign sgn_b = SIGNED && B[DW-1];
  assign mag_a = sgn_a ? -A : A;
  assign mag_b = sgn_b ? -B : B;

  // Each stage shifts one dividend bit into a DW+1 bit trial remainder and resolves one
  // quotient bit, MSB first; the remainder is restored when the trial subtract would borrow.
  for (genvar i = 1; i <= NW; i++) begin : g_iter
    logic [DW:0] trial;
    logic        no_borrow;

    assign trial     = {rem_q[i-1], quo_q[i-1][NW-1]};
    assign no_borrow = trial >= {1'b0, dvs_q[i-1]};
    assign rem_d[i]  = no_borrow ? DW'(trial - {1'b0, dvs_q[i-1]}) : trial[DW-1:0];
    assign quo_d[i]  = {quo_q[i-1][NW-2:0], no_borrow};
  end

  always_comb begin
    fix_c = negq_q[NW] ? -quo_q[NW] : quo_q[NW];
    fix_r = negr_q[NW] ? -rem_q[NW] : rem_q[NW];
  end

  always_comb begin
    c_d   = fc_q;
    r_d   = fr_q;
    dz_d  = dz_s_q[NW+1];
    ovf_d = ovf_s_q[NW+1];
    if (dz_d) begin
      c_d   = '1;
      r_d   = '0;
      ovf_d = 1'b0;
    end else if (ovf_d) begin
      c_d = MinA;
      r_d = '0;
    end
  end

  // Control and architectural outputs: the only state that reset clears
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        vld_q[i] <= 1'b0;
      end
      out_vld_q <= 1'b0;
      c_q       <= '0;
      r_q       <= '0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (!stall) begin
      vld_q[0] <= in_valid;
      for (int unsigned i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      out_vld_q <= vld_q[LAT-1];
      c_q       <= c_d;
      r_q       <= r_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
    end
  end

  // Datapath carries no reset; stale contents are masked by the cleared valid bits
  always_ff @(posedge clk) begin
    if (!stall) begin
      rem_q[0]   <= '0;
      quo_q[0]   <= mag_a;
      dvs_q[0]   <= mag_b;
      negq_q[0]  <= sgn_a ^ sgn_b;
      negr_q[0]  <= sgn_a;
      dz_s_q[0]  <= (B == '0);
      ovf_s_q[0] <= SIGNED && (A == MinA) && (B == '1);
      for (int unsigned i = 1; i <= NW; i++) begin
        rem_q[i]   <= rem_d[i];
        quo_q[i]   <= quo_d[i];
        negq_q[i]  <= negq_q[i-1];
        negr_q[i]  <= negr_q[i-1];
        dz_s_q[i]  <= dz_s_q[i-1];
        ovf_s_q[i] <= ovf_s_q[i-1];
      end
      for (int unsigned i = 1; i < NW; i++) begin
        dvs_q[i] <= dvs_q[i-1];
      end
      fc_q          <= fix_c;
      fr_q          <= fix_r;
      dz_s_q[NW+1]  <= dz_s_q[NW];
      ovf_s_q[NW+1] <= ovf_s_q[NW];
    end
  end

endmodule

// File: tb/tb_pipe_divmod.sv
// Bench for pipe_divmod: directed 8/4 vectors (both signednesses), back-pressure stream,
// mid-flight reset, and a 16/8 random sweep checked against the division identities.
module tb_pipe_divmod;

  localparam int LAT8  = 10;
  localparam int LAT16 = 18;
  localparam int NV    = 18;

  typedef struct packed {
    logic       sgn;
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] c;
    logic [3:0] r;
    logic       dz;
    logic       ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] a8;
  logic [3:0] b8;
  logic       iv8u, iv8s, or8;
  logic       ir8u, ov8u, dz8u, ovf8u, ir8s, ov8s, dz8s, ovf8s;
  logic [7:0] c8u, c8s;
  logic [3:0] r8u, r8s;

  logic [15:0] a16;
  logic [7:0]  b16;
  logic        iv16, or16;
  logic        ir16u, ov16u, dz16u, ovf16u, ir16s, ov16s, dz16s, ovf16s;
  logic [15:0] c16u, c16s;
  logic [7:0]  r16u, r16s;

  // Muxed view of the selected 8-bit instance
  logic       sel;
  logic       ir8, ov8, dz8, ovf8;
  logic [7:0] c8;
  logic [3:0] r8;
  assign ir8  = sel ? ir8s : ir8u;
  assign ov8  = sel ? ov8s : ov8u;
  assign dz8  = sel ? dz8s : dz8u;
  assign ovf8 = sel ? ovf8s : ovf8u;
  assign c8   = sel ? c8s : c8u;
  assign r8   = sel ? r8s : r8u;

  pipe_divmod #(.NW(8), .DW(4), .SIGNED(1'b0)) u_u8 (
    .clk(clk), .rst(rst), .in_valid(iv8u), .in_ready(ir8u), .A(a8), .B(b8),
    .out_valid(ov8u), .out_ready(or8), .C(c8u), .R(r8u), .dz(dz8u), .ovf(ovf8u)
  );
  pipe_divmod #(.NW(8), .DW(4), .SIGNED(1'b1)) u_s8 (
    .clk(clk), .rst(rst), .in_valid(iv8s), .in_ready(ir8s), .A(a8), .B(b8),
    .out_valid(ov8s), .out_ready(or8), .C(c8s), .R(r8s), .dz(dz8s), .ovf(ovf8s)
  );
  pipe_divmod #(.NW(16), .DW(8), .SIGNED(1'b0)) u_u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16u), .A(a16), .B(b16),
    .out_valid(ov16u), .out_ready(or16), .C(c16u), .R(r16u), .dz(dz16u), .ovf(ovf16u)
  );
  pipe_divmod #(.NW(16), .DW(8), .SIGNED(1'b1)) u_s16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16s), .A(a16), .B(b16),
    .out_valid(ov16s), .out_ready(or16), .C(c16s), .R(r16s), .dz(dz16s), .ovf(ovf16s)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // One isolated operation on the 8-bit instance chosen by v.sgn, with exact latency checks
  task automatic run_one(input vec_t v, input int idx);
    sel = v.sgn;
    @(negedge clk);
    a8   = v.a;
    b8   = v.b;
    iv8u = !v.sgn;
    iv8s = v.sgn;
    #1 chk($sformatf("v%0d_in_ready", idx), ir8, 1);
    @(posedge clk);
    #1;
    iv8u = 1'b0;
    iv8s = 1'b0;
    repeat (LAT8 - 1) @(posedge clk);
    #1 chk($sformatf("v%0d_early_valid", idx), ov8, 0);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_valid", idx), ov8, 1);
    chk($sformatf("v%0d_C", idx), c8, v.c);
    chk($sformatf("v%0d_R", idx), r8, v.r);
    chk($sformatf("v%0d_dz", idx), dz8, v.dz);
    chk($sformatf("v%0d_ovf", idx), ovf8, v.ovf);
  endtask

  task automatic check_u16(input logic [15:0] a, input logic [7:0] b);
    logic        ok;
    int unsigned prod;
    prod = int'(c16u) * int'(b) + int'(r16u);
    if (b == 8'd0) ok = (c16u == 16'hFFFF) && (r16u == 8'd0) && dz16u && !ovf16u;
    else ok = !dz16u && !ovf16u && (prod == int'(a)) && (r16u < b);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL sweep_u a=%0h b=%0h: got C=%0h R=%0h dz=%b ovf=%b, required identity and flag rules",
               a, b, c16u, r16u, dz16u, ovf16u);
    end
  endtask

  task automatic check_s16(input logic [15:0] a, input logic [7:0] b);
    logic ok;
    int   sa, sb, sc, sr, abs_r, abs_b;
    sa = $signed(a);
    sb = $signed(b);
    sc = $signed(c16s);
    sr = $signed(r16s);
    abs_r = (sr < 0) ? -sr : sr;
    abs_b = (sb < 0) ? -sb : sb;
    if (b == 8'd0) ok = (c16s == 16'hFFFF) && (r16s == 8'd0) && dz16s && !ovf16s;
    else if (a == 16'h8000 && b == 8'hFF)
      ok = (c16s == 16'h8000) && (r16s == 8'd0) && ovf16s && !dz16s;
    else ok = !dz16s && !ovf16s && (sa == sc * sb + sr) && (abs_r < abs_b) &&
              (sr == 0 || ((sr < 0) == (sa < 0)));
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL sweep_s a=%0h b=%0h: got C=%0h R=%0h dz=%b ovf=%b, required identity and flag rules",
               a, b, c16s, r16s, dz16s, ovf16s);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [NV];
    logic [7:0]  ea [20];
    logic [3:0]  eb [20];
    logic [15:0] qa [$];
    logic [7:0]  qb [$];
    logic [7:0]  snap_c;
    logic [3:0]  snap_r;
    logic        prev_stall, fire_in, fire_out;
    int          n_in, n_out;

    //                sgn   a       b      c       r      dz    ovf
    vecs[0]  = '{1'b0, 8'd200, 4'd7,  8'd28,  4'd4,  1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'd93,  4'd0,  8'd255, 4'd0,  1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'd255, 4'd1,  8'd255, 4'd0,  1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'd255, 4'd15, 8'd17,  4'd0,  1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'd0,   4'd5,  8'd0,   4'd0,  1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'd14,  4'd15, 8'd0,   4'd14, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'd128, 4'd3,  8'd42,  4'd2,  1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'd0,   4'd0,  8'd255, 4'd0,  1'b1, 1'b0};
    vecs[8]  = '{1'b1, 8'h9C,  4'h7,  8'hF2,  4'hE,  1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'h9C,  4'h9,  8'h0E,  4'hE,  1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h80,  4'hF,  8'h80,  4'h0,  1'b0, 1'b1};
    vecs[11] = '{1'b1, 8'h64,  4'h9,  8'hF2,  4'h2,  1'b0, 1'b0};
    vecs[12] = '{1'b1, 8'h80,  4'h0,  8'hFF,  4'h0,  1'b1, 1'b0};
    vecs[13] = '{1'b1, 8'h7F,  4'h8,  8'hF1,  4'h7,  1'b0, 1'b0};
    vecs[14] = '{1'b1, 8'h81,  4'h7,  8'hEE,  4'hF,  1'b0, 1'b0};
    vecs[15] = '{1'b1, 8'h80,  4'h1,  8'h80,  4'h0,  1'b0, 1'b0};
    vecs[16] = '{1'b1, 8'h05,  4'hF,  8'hFB,  4'h0,  1'b0, 1'b0};
    vecs[17] = '{1'b1, 8'h7F,  4'hF,  8'h81,  4'h0,  1'b0, 1'b0};

    rst  = 1'b0;
    sel  = 1'b0;
    a8   = '0;
    b8   = '0;
    iv8u = 1'b0;
    iv8s = 1'b0;
    or8  = 1'b1;
    a16  = '0;
    b16  = '0;
    iv16 = 1'b0;
    or16 = 1'b1;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_in_ready", ir8u, 1);
    chk("rst_valid_u8", ov8u, 0);
    chk("rst_C", c8u, 0);
    chk("rst_R", r8u, 0);
    chk("rst_dz", dz8u, 0);
    chk("rst_ovf", ovf8u, 0);
    chk("rst_valid_s8", ov8s, 0);
    chk("rst_valid_16", {ov16u, ov16s}, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) run_one(vecs[i], i);

    // Back-pressure stream on the unsigned 8-bit instance
    sel = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ea[i] = 8'($urandom_range(0, 255));
      eb[i] = 4'($urandom_range(1, 15));
    end
    n_in       = 0;
    n_out      = 0;
    prev_stall = 1'b0;
    snap_c     = '0;
    snap_r     = '0;
    @(negedge clk);
    for (int cyc = 0; cyc < 400 && n_out < 20; cyc++) begin
      iv8u = (n_in < 20);
      a8   = (n_in < 20) ? ea[n_in] : 8'd0;
      b8   = (n_in < 20) ? eb[n_in] : 4'd0;
      or8  = 1'($urandom_range(0, 1));
      #1;
      chk("bp_in_ready", ir8u, !(ov8u && !or8));
      if (prev_stall) begin
        chk("bp_hold_valid", ov8u, 1);
        chk("bp_hold_C", c8u, snap_c);
        chk("bp_hold_R", r8u, snap_r);
      end
      prev_stall = ov8u && !or8;
      snap_c     = c8u;
      snap_r     = r8u;
      fire_in    = iv8u && ir8u;
      fire_out   = ov8u && or8;
      if (fire_out) begin
        chk($sformatf("bp_C%0d", n_out), c8u, ea[n_out] / eb[n_out]);
        chk($sformatf("bp_R%0d", n_out), r8u, ea[n_out] % eb[n_out]);
        n_out++;
      end
      @(negedge clk);
      if (fire_in) n_in++;
    end
    chk("bp_count", n_out, 20);
    iv8u = 1'b0;
    or8  = 1'b1;

    // Reset mid-flight: four ops accepted, the fifth is presented on the reset edge
    repeat (LAT8 + 2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      a8   = 8'(50 + i * 20);
      b8   = 4'(i + 3);
      iv8u = 1'b1;
      if (i == 4) rst = 1'b0;
      #1;
      if (i == 4) chk("mid_rst_in_ready", ir8u, 1);
      @(negedge clk);
    end
    rst  = 1'b1;
    iv8u = 1'b0;
    #1;
    chk("mid_rst_C", c8u, 0);
    chk("mid_rst_R", r8u, 0);
    for (int i = 0; i < LAT8; i++) begin
      @(posedge clk);
      #1 chk($sformatf("mid_rst_quiet%0d", i), ov8u, 0);
    end
    run_one('{1'b0, 8'd77, 4'd5, 8'd15, 4'd2, 1'b0, 1'b0}, 100);

    // 16/8 sweep, both signednesses fed the same stream
    @(negedge clk);
    for (int cyc = 0; cyc < 1000 + LAT16 + 4; cyc++) begin
      if (cyc < 1000) begin
        logic [15:0] ta;
        logic [7:0]  tb;
        int          pick;
        pick = int'($urandom_range(0, 15));
        ta   = 16'($urandom);
        tb   = 8'($urandom);
        if (pick == 0) tb = 8'd0;
        else if (pick == 1) begin
          ta = 16'h8000;
          tb = 8'hFF;
        end else if (pick == 2) ta = 16'h8000;
        else if (pick == 3) tb = 8'hFF;
        a16  = ta;
        b16  = tb;
        iv16 = 1'b1;
        qa.push_back(ta);
        qb.push_back(tb);
      end else begin
        iv16 = 1'b0;
      end
      #1;
      chk("sweep_in_ready", ir16u && ir16s, 1);
      if (ov16u || ov16s) begin
        chk("sweep_valid_pair", {ov16u, ov16s}, 2'b11);
        if (qa.size() > 0) begin
          check_u16(qa[0], qb[0]);
          check_s16(qa[0], qb[0]);
          void'(qa.pop_front());
          void'(qb.pop_front());
        end else begin
          chk("sweep_unexpected_result", qa.size(), 1);
        end
      end
      @(negedge clk);
    end
    chk("sweep_drained", qa.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_divmod.md
Name: pipe_divmod

Overview:
- Parametrised pipelined integer divider with valid/ready handshake; next generation of the fixed-width pipelined divider.
- Produces quotient, remainder, divide-by-zero and signed-overflow flags. Accepts one operation per cycle.
- Supports unsigned or signed (truncating) division, selected at elaboration.
- Sits between a streaming producer and consumer; the whole pipeline stalls under back-pressure.

Parameters:
- NW, 8, dividend and quotient width in bits (NW >= DW)
- DW, 4, divisor and remainder width in bits (DW >= 2)
- SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands, truncation toward zero
- LAT, NW+2, derived (localparam), pipeline latency in cycles: 1 input stage + NW iteration stages + 1 output stage

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  A/B valid
- in_ready  out  1  pipeline can accept this cycle
- A  in  NW  dividend
- B  in  DW  divisor
- out_valid  out  1  C/R/flags valid
- out_ready  in  1  consumer accepts this cycle
- C  out  NW  quotient
- R  out  DW  remainder
- dz  out  1  divide-by-zero for this result
- ovf  out  1  signed overflow for this result (always 0 when SIGNED=0)

Behaviour:
- Reset: one clock and a synchronous, active-low reset. rst=0 sampled at a rising clk edge clears the following:
  - all stage valid bits, so out_valid=0;
  - C=0, R=0, dz=0, ovf=0.
  - in_ready=1 during and after reset.
  - In-flight operations are discarded and never emerge.
- Stall: stall = out_valid & ~out_ready; in_ready = ~stall.
  - On stall, every stage register holds, including bubbles.
  - Otherwise every stage advances one position per cycle.
- Accept: an operation enters when in_valid & in_ready at a rising edge. in_valid with in_ready=0 is ignored; the producer holds it.
- Latency:
  - With no stall, an operation accepted at edge k shows out_valid=1 and its results after edge k+LAT.
  - Each stall cycle adds one cycle.
  - Results stay stable while out_valid & ~out_ready.
- Throughput: one result per cycle with continuous in_valid and out_ready. Results leave in acceptance order. No loss and no duplication.
- Stage 0 (input):
  - Registers A and B, the valid bit and the operand signs.
  - SIGNED=1 converts operands to magnitudes: |A| in NW bits unsigned, |B| in DW bits unsigned.
  - Flags dz (B==0) and ovf (SIGNED & A==-2^(NW-1) & B==all-ones, i.e. -1).
- Stages 1..NW (restoring iteration):
  - Stage i resolves quotient bit NW-i, MSB first.
  - The partial remainder is DW+1 bits wide.
  - Trial subtract of the divisor magnitude; the bit is 1 when there is no borrow, and the remainder is restored when there is a borrow.
- Stage NW+1 (output):
  - SIGNED=1: quotient is negated when sign(A) xor sign(B); remainder is negated when A<0, so the remainder sign follows the dividend.
  - Exceptional values override the computed result:
    - dz=1: C = all ones, R = 0, ovf = 0.
    - ovf=1: C = -2^(NW-1) (pattern 1 followed by zeros), R = 0.
  - dz and ovf are per result and valid only while out_valid=1.
- Unsigned identity for every non-dz result: A == C*B + R and R < B.
- Signed identity for every non-dz, non-ovf result: A == C*B + R, |R| < |B|, and R is 0 or has the sign of A.
- Simultaneous events: the pipeline can accept an input and emit an output on the same edge. A stall in the same cycle as in_valid blocks acceptance.

Test Plan:
- Defaults, SIGNED=0:
  - A=200, B=7 accepted at edge k -> out_valid rises after edge k+10; C=28, R=4, dz=0, ovf=0.
  - A=93, B=0 -> C=255, R=0, dz=1.
- SIGNED=1:
  - A=-100 (0x9C), B=7 -> C=-14 (0xF2), R=-2 (0xE).
  - A=-100, B=-7 (0x9) -> C=14 (0x0E), R=-2 (0xE).
  - A=-128 (0x80), B=-1 (0xF) -> C=0x80, R=0, ovf=1, dz=0.
- Back-pressure: stream 20 random unsigned pairs back-to-back with out_ready driven by a pseudo-random 50% pattern. Required:
  - all 20 results arrive in order and match A/B and A%B;
  - in_ready==~(out_valid&~out_ready) every cycle;
  - outputs are stable during stalls.
- Reset mid-flight: accept 5 operations, drive rst=0 for one edge at edge k+4, then release.
  - out_valid stays 0 for the next LAT cycles.
  - A new operation accepted after release emerges LAT cycles later with the correct result.
- Parameter sweep: NW=16, DW=8, both SIGNED values, 1000 random pairs including B=0 and the A=min/B=-1 corners. The identities above hold, and the dz/ovf rules hold for every result.
